inverse_zigzag_stream: RTL and testbench

INVERSE_ZIGZAG_STREAM -- requirements
Module: inverse_zigzag_stream

---
 rtl/zigzag_pkg.sv | 31 +++
 rtl/zigzag_bank_ram.sv | 36 +++
 rtl/inverse_zigzag_stream.sv | 149 ++++++++++++++
 tb/tb_inverse_zigzag_stream.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zigzag_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : zigzag_pkg
//  Brief    : Shared block size, JPEG zigzag-to-raster table and bank states.
//  Revision : 1.0 - initial release
// ============================================================================
package zigzag_pkg;

    localparam int PIXEL_COUNT = 64;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Entry k is the raster (row-major) position of the k-th zigzag coefficient.
    localparam logic [5:0] ZZ_TO_RASTER [PIXEL_COUNT] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

endpackage
`default_nettype wire

// File: rtl/zigzag_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module   : zigzag_bank_ram
//  Brief    : One coefficient bank; simple dual-port RAM, synchronous read.
//  Revision : 1.0 - initial release
// ============================================================================
module zigzag_bank_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read data holds while re_i is low so a stalled reader keeps its word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/inverse_zigzag_stream.sv
`default_nettype none
// ============================================================================
//  Module   : inverse_zigzag_stream
//  Brief    : Streams zigzag-order 8x8 blocks in, raster-order blocks out,
//             through two ping-pong banks and a two-stage read pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module inverse_zigzag_stream
    import zigzag_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  err_last
);

    localparam int                ADDR_W   = $clog2(DATA_DEPTH * DATA_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXEL_COUNT - 1);

    bank_state_e           bank_state_q [2];
    bank_state_e           bank_state_d [2];
    logic                  wr_bank_q;
    logic                  rd_bank_q;
    logic [ADDR_W-1:0]     wr_cnt_q;
    logic [ADDR_W-1:0]     rd_cnt_q;
    logic                  s1_valid_q;
    logic                  s1_last_q;
    logic                  s1_bank_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  err_last_q;

    logic                  w_wr_fire;
    logic                  w_rd_avail;
    logic                  w_s2_adv;
    logic                  w_s1_adv;
    logic                  w_fetch;
    logic [ADDR_W-1:0]     w_wr_addr;
    logic [DATA_WIDTH-1:0] w_rdata [2];
    logic [DATA_WIDTH-1:0] w_s1_data;

    assign in_ready   = (bank_state_q[wr_bank_q] == BANK_EMPTY) ||
                        (bank_state_q[wr_bank_q] == BANK_FILLING);
    assign w_wr_fire  = in_valid && in_ready;
    assign w_wr_addr  = ZZ_TO_RASTER[wr_cnt_q];
    assign w_rd_avail = (bank_state_q[rd_bank_q] == BANK_FULL) ||
                        (bank_state_q[rd_bank_q] == BANK_DRAINING);
    assign w_s2_adv   = !out_valid_q || out_ready;
    assign w_s1_adv   = !s1_valid_q || w_s2_adv;
    assign w_fetch    = w_rd_avail && w_s1_adv;
    assign w_s1_data  = w_rdata[s1_bank_q];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        zigzag_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_W)
        ) u_ram (
            .clk     (clk),
            .we_i    (w_wr_fire && (wr_bank_q == 1'(g))),
            .waddr_i (w_wr_addr),
            .wdata_i (in_data),
            .re_i    (w_fetch && (rd_bank_q == 1'(g))),
            .raddr_i (rd_cnt_q),
            .rdata_o (w_rdata[g])
        );
    end

    // A bank is released as soon as its last word is read into the output
    // pipeline; that word no longer depends on the RAM, so refill can start
    // without a gap between blocks.
    always_comb begin
        bank_state_d = bank_state_q;
        for (int b = 0; b < 2; b++) begin
            if (w_wr_fire && (wr_bank_q == 1'(b))) begin
                bank_state_d[b] = (wr_cnt_q == LAST_IDX) ? BANK_FULL : BANK_FILLING;
            end
            if (w_fetch && (rd_bank_q == 1'(b))) begin
                bank_state_d[b] = (rd_cnt_q == LAST_IDX) ? BANK_EMPTY : BANK_DRAINING;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_state_q[0] <= BANK_EMPTY;
            bank_state_q[1] <= BANK_EMPTY;
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            wr_cnt_q        <= '0;
            rd_cnt_q        <= '0;
            s1_valid_q      <= 1'b0;
            s1_last_q       <= 1'b0;
            s1_bank_q       <= 1'b0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            out_data_q      <= '0;
            err_last_q      <= 1'b0;
        end else begin
            bank_state_q[0] <= bank_state_d[0];
            bank_state_q[1] <= bank_state_d[1];
            // Framing follows wr_cnt_q alone; in_last only feeds the error flag.
            if (w_wr_fire) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                if (wr_cnt_q == LAST_IDX) begin
                    wr_bank_q <= !wr_bank_q;
                end
                if (in_last != (wr_cnt_q == LAST_IDX)) begin
                    err_last_q <= 1'b1;
                end
            end
            if (w_fetch) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    rd_bank_q <= !rd_bank_q;
                end
            end
            if (w_s1_adv) begin
                s1_valid_q <= w_fetch;
                s1_last_q  <= (rd_cnt_q == LAST_IDX);
                s1_bank_q  <= rd_bank_q;
            end
            if (w_s2_adv) begin
                out_valid_q <= s1_valid_q;
                out_last_q  <= s1_valid_q && s1_last_q;
                if (s1_valid_q) begin
                    out_data_q <= w_s1_data;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign err_last  = err_last_q;

endmodule
`default_nettype wire

// File: tb/tb_inverse_zigzag_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inverse_zigzag_stream
//  Brief    : Scoreboard bench for inverse_zigzag_stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inverse_zigzag_stream;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          err_last;

    inverse_zigzag_stream #(.DATA_WIDTH(DW), .DATA_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err_last  (err_last)
    );

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            zz [64];
    logic [DW:0]   exp_q [$];
    logic [DW:0]   e_pop;
    logic [DW-1:0] blk [64];
    logic [DW-1:0] ras [64];
    logic [DW-1:0] cap [64];
    int            k_in = 0;
    logic          exp_err = 1'b0;
    int            n_out = 0;
    int            obs_idx = 0;
    int            last_acc_edge = 0;
    int            rise_cyc = 0;
    int            mark_n = 0;
    int            first_mark = 0;
    int            last_out_cyc = 0;
    int            stall_cnt = 0;
    logic          prev_valid = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    bit            chk_en = 1'b0;
    int            rdy_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Zigzag walk derived from the diagonal scan itself.
    initial begin
        int r, c;
        r = 0;
        c = 0;
        for (int k = 0; k < 64; k++) begin
            zz[k] = r * 8 + c;
            if (((r + c) % 2) == 0) begin
                if (c == 7)      r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7)      c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end
    end

    // Monitor: state checks first (pre-edge view), then model update for the coming edge.
    initial forever begin
        @(negedge clk);
        if (!rst && chk_en) begin
            if (exp_q.size() <= 64 || exp_q.size() > 66) begin
                total++;
                if (in_ready !== (exp_q.size() <= 64)) begin
                    bad++;
                    $display("FAIL bank_occupancy cyc=%0d in_ready=%b want=%b queued=%0d",
                             cyc, in_ready, (exp_q.size() <= 64), exp_q.size());
                end
            end
            total++;
            if (err_last !== exp_err) begin
                bad++;
                $display("FAIL err_last cyc=%0d got=%b want=%b", cyc, err_last, exp_err);
            end
            if (prev_stall && out_valid) begin
                total++;
                if (out_data !== prev_data || out_last !== prev_last) begin
                    bad++;
                    $display("FAIL hold cyc=%0d got=%h/%b want=%h/%b",
                             cyc, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid && !prev_valid) rise_cyc = cyc;
            if (in_valid && in_ready) begin
                blk[k_in] = in_data;
                if (in_last !== (k_in == 63)) exp_err = 1'b1;
                k_in++;
                if (k_in == 64) begin
                    for (int i = 0; i < 64; i++) ras[zz[i]] = blk[i];
                    for (int r = 0; r < 64; r++) exp_q.push_back({(r == 63), ras[r]});
                    k_in = 0;
                    last_acc_edge = cyc + 1;
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                last_out_cyc = cyc + 1;
                if (n_out == mark_n + 1) first_mark = cyc + 1;
                cap[obs_idx] = out_data;
                obs_idx = (obs_idx + 1) % 64;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output cyc=%0d got=%h last=%b", cyc, out_data, out_last);
                end else begin
                    e_pop = exp_q.pop_front();
                    if ({out_last, out_data} !== e_pop) begin
                        bad++;
                        $display("FAIL scoreboard cyc=%0d got=%b/%h want=%b/%h",
                                 cyc, out_last, out_data, e_pop[DW], e_pop[DW-1:0]);
                    end
                end
            end
            prev_valid = out_valid;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send(input logic [DW-1:0] d, input logic l);
        int   n;
        logic acc;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 2000);
        in_valid = 1'b0;
        stall_cnt += n - 1;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout cyc=%0d got=no_accept want=accept", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++;
        if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        total++;
        if (err_last !== 1'b0) begin bad++; $display("FAIL reset_err_last got=%b want=0", err_last); end
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_single_block();
        int pos [7] = '{0, 1, 2, 3, 4, 8, 63};
        int val [7] = '{0, 1, 5, 6, 14, 2, 63};
        rdy_mode = 0;
        for (int k = 0; k < 64; k++) send(DW'(k), (k == 63));
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL single_drain got=%0d want=0", exp_q.size()); end
        total++;
        if (rise_cyc - last_acc_edge != 2) begin
            bad++;
            $display("FAIL single_latency got=%0d want=2", rise_cyc - last_acc_edge);
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (cap[pos[i]] !== DW'(val[i])) begin
                bad++;
                $display("FAIL single_raster[%0d] got=%0d want=%0d", pos[i], cap[pos[i]], val[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        rdy_mode = 0;
        stall_cnt = 0;
        mark_n = n_out;
        for (int b = 0; b < 100; b++)
            for (int k = 0; k < 64; k++) send($urandom, (k == 63));
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (stall_cnt != 0) begin bad++; $display("FAIL b2b_input_stalls got=%0d want=0", stall_cnt); end
        total++;
        if (n_out - mark_n != 6400) begin bad++; $display("FAIL b2b_count got=%0d want=6400", n_out - mark_n); end
        total++;
        if (last_out_cyc - first_mark != 6399) begin
            bad++;
            $display("FAIL b2b_output_span got=%0d want=6399", last_out_cyc - first_mark);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        rdy_mode = 1;
        mark_n = n_out;
        @(posedge clk);
        #1;
        for (int c = 0; c < 150; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hB000_0000 + DW'(acc);
            in_last  = ((acc % 64) == 63);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        total++;
        if (acc != 128) begin bad++; $display("FAIL bp_accepted got=%0d want=128", acc); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        rdy_mode = 0;
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (n_out - mark_n != 128) begin bad++; $display("FAIL bp_released got=%0d want=128", n_out - mark_n); end
    endtask

    task automatic test_reset_mid_block();
        rdy_mode = 0;
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 64; k++) send($urandom, (k == 63));
        for (int k = 0; k < 30; k++) send($urandom, 1'b0);
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b/%h/%b want=0/0/0", out_valid, out_data, out_last);
        end
        exp_q.delete();
        k_in = 0;
        obs_idx = 0;
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 64; k++) send(DW'(100 + k), (k == 63));
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL midrst_drain got=%0d want=0", exp_q.size()); end
        total++;
        if (rise_cyc - last_acc_edge != 2) begin
            bad++;
            $display("FAIL midrst_latency got=%0d want=2", rise_cyc - last_acc_edge);
        end
        total++;
        if (cap[8] !== DW'(102)) begin bad++; $display("FAIL midrst_raster8 got=%0d want=102", cap[8]); end
    endtask

    task automatic test_err_last();
        rdy_mode = 0;
        for (int k = 0; k < 64; k++) send($urandom, (k == 10) || (k == 63));
        total++;
        if (err_last !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", err_last); end
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL err_drain got=%0d want=0", exp_q.size()); end
        total++;
        if (err_last !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err_last); end
    endtask

    task automatic test_random();
        rdy_mode = 2;
        mark_n = n_out;
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < 64; k++) begin
                while ($urandom_range(0, 1) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send($urandom, (k == 63));
            end
        end
        for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(posedge clk);
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL random_drain got=%0d want=0", exp_q.size()); end
        total++;
        if (n_out - mark_n != 1280) begin bad++; $display("FAIL random_count got=%0d want=1280", n_out - mark_n); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_block();
        test_err_last();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
